// File: rtl/uop_buffer_pkg.sv
// Shared types and defaults for the micro-op bundle buffer that sits
// between the decoder/loader and uop_fetch.
package uop_buffer_pkg;

  localparam int UOP_BUF_SIZE_DEFAULT = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } fetched_instruction;

  typedef struct packed {
    fetched_instruction slot1;
    fetched_instruction slot0;
  } instruction_bundle;

endpackage

// File: rtl/uop_buffer_chk.sv
// Protocol checks for uop_buffer: legal parameterisation, single-step
// reader advances, and no write colliding with an underrun.
module uop_buffer_chk #(
  parameter int  UOP_BUF_SIZE = 16,
  localparam int ADDR_W       = $clog2(UOP_BUF_SIZE)
) (
  input logic              clk,
  input logic              reset,
  input logic              clear,
  input logic              consume,
  input logic              accept,
  input logic              count_zero,
  input logic [ADDR_W-1:0] rd_addr,
  input logic [ADDR_W-1:0] rd_addr_q
);

  if (UOP_BUF_SIZE < 2 || (UOP_BUF_SIZE & (UOP_BUF_SIZE - 1)) != 0) begin : g_bad_size
    $error("uop_buffer: UOP_BUF_SIZE must be a power of two >= 2");
  end

  // Reader must step by exactly one entry; a write during an underrun is lost
  always @(posedge clk) begin
    if (reset && !clear && consume) begin
      assert (rd_addr == rd_addr_q + ADDR_W'(1))
        else $error("uop_buffer: illegal read address jump");
      assert (!(count_zero && accept))
        else $error("uop_buffer: write lost during underrun");
    end
  end

endmodule

// File: rtl/uop_buffer_mem.sv
// Bundle storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module uop_buffer_mem
  import uop_buffer_pkg::*;
#(
  parameter int  DEPTH  = UOP_BUF_SIZE_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  instruction_bundle wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output instruction_bundle rd_data
);

  instruction_bundle mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uop_buffer.sv
// Circular micro-op bundle buffer. Consumption is inferred from advances of
// uop_fetch's read address; the writer is back-pressured with a registered stall.
module uop_buffer
  import uop_buffer_pkg::*;
#(
  parameter int  UOP_BUF_SIZE = UOP_BUF_SIZE_DEFAULT,
  localparam int ADDR_W       = $clog2(UOP_BUF_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_valid,
  input  instruction_bundle wr_bundle,
  output logic              stalled,
  input  logic [ADDR_W-1:0] rd_addr,
  output instruction_bundle rd_bundle,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              underrun
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(UOP_BUF_SIZE);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W:0]   count_r;
  logic              stalled_r;
  logic              underrun_r;

  logic              consume_s;
  logic              accept_s;
  logic              underrun_evt_s;
  logic [ADDR_W:0]   next_count_s;
  logic [ADDR_W-1:0] next_wr_ptr_s;
  logic              next_stalled_s;

  assign consume_s      = (rd_addr != rd_addr_r);
  assign accept_s       = wr_valid & ~stalled_r & reset & ~clear;
  assign underrun_evt_s = consume_s & (count_r == '0);

  // Joint accept/consume evaluation; an underrun re-aligns the writer to the reader
  always_comb begin
    next_count_s  = count_r;
    next_wr_ptr_s = wr_ptr_r;
    if (underrun_evt_s) begin
      next_count_s  = '0;
      next_wr_ptr_s = rd_addr;
    end else begin
      case ({accept_s, consume_s})
        2'b10: begin
          next_count_s  = count_r + CNT_ONE;
          next_wr_ptr_s = wr_ptr_r + PTR_ONE;
        end
        2'b01: begin
          next_count_s  = count_r - CNT_ONE;
          next_wr_ptr_s = wr_ptr_r;
        end
        2'b11: begin
          next_count_s  = count_r;
          next_wr_ptr_s = wr_ptr_r + PTR_ONE;
        end
        default: begin
          next_count_s  = count_r;
          next_wr_ptr_s = wr_ptr_r;
        end
      endcase
    end
    next_stalled_s = (next_count_s == FULL_COUNT);
  end

  // Control state: reset beats clear beats normal update
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_addr_r  <= '0;
      count_r    <= '0;
      stalled_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_addr_r  <= '0;
      count_r    <= '0;
      stalled_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      wr_ptr_r   <= next_wr_ptr_s;
      rd_addr_r  <= rd_addr;
      count_r    <= next_count_s;
      stalled_r  <= next_stalled_s;
      underrun_r <= underrun_r | underrun_evt_s;
    end
  end

  uop_buffer_mem #(.DEPTH(UOP_BUF_SIZE)) u_mem (
    .clk     (clk),
    .wr_en   (accept_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_bundle),
    .rd_addr (rd_addr),
    .rd_data (rd_bundle)
  );

  uop_buffer_chk #(.UOP_BUF_SIZE(UOP_BUF_SIZE)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .consume    (consume_s),
    .accept     (accept_s),
    .count_zero (count_r == '0),
    .rd_addr    (rd_addr),
    .rd_addr_q  (rd_addr_r)
  );

  assign stalled  = stalled_r;
  assign count    = count_r;
  assign underrun = underrun_r;
  assign rd_valid = (count_r != '0);

endmodule

// File: tb/tb_uop_buffer.sv
// Directed, table-driven bench for uop_buffer with a 4-entry buffer, plus a
// hand-written fill-until-stall / FIFO-order drain sequence.
module tb_uop_buffer;
  import uop_buffer_pkg::*;

  localparam int SIZE = 4;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              wr_valid;
  instruction_bundle wr_bundle;
  logic              stalled;
  logic [AW-1:0]     rd_addr;
  instruction_bundle rd_bundle;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              underrun;

  always #5 clk = ~clk;

  uop_buffer #(.UOP_BUF_SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .wr_bundle (wr_bundle),
    .stalled   (stalled),
    .rd_addr   (rd_addr),
    .rd_bundle (rd_bundle),
    .rd_valid  (rd_valid),
    .count     (count),
    .underrun  (underrun)
  );

  typedef struct {
    logic          rst;
    logic          clr;
    logic          wv;
    logic [7:0]    wtag;
    logic [AW-1:0] ra;
    logic [AW:0]   cnt;
    logic          stl;
    logic          rv;
    logic          und;
    logic          chk;
    logic [7:0]    dtag;
  } vec_t;

  vec_t vecs [29];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic instruction_bundle mk(input logic [7:0] tag);
    instruction_bundle b;
    b.slot0.valid = 1'b1;
    b.slot0.instr = {tag, 8'h11, ~tag, 8'h22};
    b.slot1.valid = tag[0];
    b.slot1.instr = {8'h33, tag, 8'h44, tag};
    return b;
  endfunction

  function automatic vec_t v(input logic rst, input logic clr, input logic wv,
                             input logic [7:0] wtag, input logic [AW-1:0] ra,
                             input logic [AW:0] cnt, input logic stl, input logic rv,
                             input logic und, input logic chk, input logic [7:0] dtag);
    vec_t r;
    r.rst = rst; r.clr = clr; r.wv = wv; r.wtag = wtag; r.ra = ra;
    r.cnt = cnt; r.stl = stl; r.rv = rv; r.und = und; r.chk = chk; r.dtag = dtag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int written;
    reset = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_bundle = mk(8'd0); rd_addr = '0;

    //              rst   clr   wv    wtag    ra     cnt   stl   rv    und   chk   dtag
    vecs[0]  = v(1'b0, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[1]  = v(1'b0, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[2]  = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[3]  = v(1'b1, 1'b0, 1'b1, 8'd1,  2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    vecs[4]  = v(1'b1, 1'b0, 1'b1, 8'd2,  2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    vecs[5]  = v(1'b1, 1'b0, 1'b1, 8'd3,  2'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    vecs[6]  = v(1'b1, 1'b0, 1'b1, 8'd4,  2'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    vecs[7]  = v(1'b1, 1'b0, 1'b1, 8'd5,  2'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    vecs[8]  = v(1'b1, 1'b0, 1'b1, 8'd5,  2'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    vecs[9]  = v(1'b1, 1'b0, 1'b1, 8'd5,  2'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    vecs[10] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd2, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
    vecs[11] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
    vecs[12] = v(1'b1, 1'b0, 1'b1, 8'd8,  2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
    vecs[13] = v(1'b1, 1'b0, 1'b1, 8'd9,  2'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd8);
    vecs[14] = v(1'b1, 1'b0, 1'b1, 8'd10, 2'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
    vecs[15] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd3, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd10);
    vecs[16] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[17] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[18] = v(1'b1, 1'b0, 1'b1, 8'd6,  2'd1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6);
    vecs[19] = v(1'b1, 1'b0, 1'b1, 8'd11, 2'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6);
    vecs[20] = v(1'b1, 1'b0, 1'b1, 8'd12, 2'd1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6);
    vecs[21] = v(1'b1, 1'b1, 1'b1, 8'd7,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    vecs[22] = v(1'b1, 1'b0, 1'b1, 8'd13, 2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd13);
    vecs[23] = v(1'b1, 1'b0, 1'b1, 8'd14, 2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd13);
    vecs[24] = v(1'b1, 1'b0, 1'b1, 8'd15, 2'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd13);
    vecs[25] = v(1'b0, 1'b0, 1'b1, 8'd7,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd13);
    vecs[26] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd13);
    vecs[27] = v(1'b1, 1'b0, 1'b0, 8'd0,  2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    vecs[28] = v(1'b0, 1'b0, 1'b0, 8'd0,  2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 29; i++) begin
      reset     = vecs[i].rst;
      clear     = vecs[i].clr;
      wr_valid  = vecs[i].wv;
      wr_bundle = mk(vecs[i].wtag);
      rd_addr   = vecs[i].ra;
      step();
      chk($sformatf("v%0d count", i),    128'(count),    128'(vecs[i].cnt));
      chk($sformatf("v%0d stalled", i),  128'(stalled),  128'(vecs[i].stl));
      chk($sformatf("v%0d rd_valid", i), 128'(rd_valid), 128'(vecs[i].rv));
      chk($sformatf("v%0d underrun", i), 128'(underrun), 128'(vecs[i].und));
      if (vecs[i].chk)
        chk($sformatf("v%0d rd_bundle", i), 128'(rd_bundle), 128'(mk(vecs[i].dtag)));
    end

    // Fill until the buffer stalls (bounded), then drain checking FIFO order
    reset = 1'b1; clear = 1'b0; rd_addr = '0;
    written = 0;
    for (int i = 0; i < 10; i++) begin
      if (stalled) break;
      wr_valid  = 1'b1;
      wr_bundle = mk(8'(8'd20 + i));
      step();
      written++;
    end
    wr_valid = 1'b0;
    chk("fill stalled", 128'(stalled), 128'(1'b1));
    chk("fill writes", 128'(written), 128'(SIZE));
    chk("fill count", 128'(count), 128'(SIZE));
    for (int k = 0; k < SIZE; k++) begin
      chk($sformatf("drain%0d data", k), 128'(rd_bundle), 128'(mk(8'(8'd20 + k))));
      rd_addr = AW'(k + 1);
      step();
      chk($sformatf("drain%0d count", k), 128'(count), 128'(SIZE - 1 - k));
    end
    chk("drain rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("drain underrun", 128'(underrun), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
